// File: rtl/strobe_pkg.sv
// Shared types and helpers for the strobe divider bank.
// Pure declarations; no timing or flow-control behaviour of its own.
// Consumers decode raw mode bits and clamp divisors through these helpers.
package strobe_pkg;

    typedef enum logic [1:0] {
        MODE_OFF     = 2'd0,
        MODE_CONT    = 2'd1,
        MODE_ONESHOT = 2'd2
    } mode_e;

    // Divisors below 2 cannot produce a distinct strobe cycle, so they become 2.
    function automatic logic [63:0] clamp_div(input logic [63:0] div);
        return (div < 64'd2) ? 64'd2 : div;
    endfunction

    function automatic mode_e decode_mode(input logic [1:0] raw);
        case (raw)
            2'd1:    return MODE_CONT;
            2'd2:    return MODE_ONESHOT;
            default: return MODE_OFF;
        endcase
    endfunction

endpackage

// File: rtl/strobe_div_chan.sv
// One divider channel: counter, active div/mode, shadow config and one-shot state.
// Strobe is combinational from registers (0-cycle); config applies one edge after accept at the earliest.
// A config write is taken only while nothing is pending; the bank turns that into cfg back-pressure.
module strobe_div_chan
    import strobe_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int DEFAULT_DIV = 10
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_cfg_wr,
    input  logic [CNT_W-1:0] i_cfg_div,
    input  logic [1:0]       i_cfg_mode,
    input  logic             i_start,
    input  logic             i_sync,
    output logic             o_strobe,
    output logic             o_busy,
    output logic             o_pending
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] div_q, div_d;
    logic [CNT_W-1:0] sh_div_q, sh_div_d;
    mode_e            mode_q, mode_d;
    mode_e            sh_mode_q, sh_mode_d;
    logic             busy_q, busy_d;
    logic             pend_q, pend_d;

    logic at_end;
    logic active;
    logic strobe;
    logic apply_ok;

    assign at_end   = (cnt_q == div_q - CNT_W'(1));
    assign active   = (mode_q == MODE_CONT) || ((mode_q == MODE_ONESHOT) && busy_q);
    assign strobe   = active && at_end;
    // Boundaries where swapping div/mode cannot cut a period short.
    assign apply_ok = pend_q && ((mode_q == MODE_OFF) ||
                                 ((mode_q == MODE_ONESHOT) && !busy_q) || strobe);

    always_comb begin
        cnt_d     = cnt_q;
        div_d     = div_q;
        mode_d    = mode_q;
        sh_div_d  = sh_div_q;
        sh_mode_d = sh_mode_q;
        busy_d    = busy_q;
        pend_d    = pend_q;

        if (i_cfg_wr && !pend_q) begin
            sh_div_d  = CNT_W'(clamp_div(64'(i_cfg_div)));
            sh_mode_d = decode_mode(i_cfg_mode);
            pend_d    = 1'b1;
        end

        if (i_sync) begin
            cnt_d = '0;
            if (pend_q) begin
                div_d  = sh_div_q;
                mode_d = sh_mode_q;
                busy_d = 1'b0;
                pend_d = 1'b0;
            end
        end else if (apply_ok) begin
            cnt_d  = '0;
            div_d  = sh_div_q;
            mode_d = sh_mode_q;
            busy_d = 1'b0;
            pend_d = 1'b0;
        end else begin
            case (mode_q)
                MODE_CONT: begin
                    cnt_d  = at_end ? '0 : cnt_q + CNT_W'(1);
                    busy_d = 1'b0;
                end
                MODE_ONESHOT: begin
                    if (!busy_q) begin
                        if (i_start) begin
                            busy_d = 1'b1;
                            cnt_d  = '0;
                        end
                    end else if (at_end) begin
                        // A start on the strobe cycle chains the next shot with no gap.
                        busy_d = i_start;
                        cnt_d  = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    cnt_d  = '0;
                    busy_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            cnt_q     <= '0;
            div_q     <= CNT_W'(DEFAULT_DIV);
            mode_q    <= MODE_CONT;
            sh_div_q  <= CNT_W'(DEFAULT_DIV);
            sh_mode_q <= MODE_CONT;
            busy_q    <= 1'b0;
            pend_q    <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            div_q     <= div_d;
            mode_q    <= mode_d;
            sh_div_q  <= sh_div_d;
            sh_mode_q <= sh_mode_d;
            busy_q    <= busy_d;
            pend_q    <= pend_d;
        end
    end

    assign o_strobe  = strobe;
    assign o_busy    = busy_q;
    assign o_pending = pend_q;

endmodule

// File: rtl/strobe_div_bank.sv
// Bank of independent programmable strobe dividers with a shared re-align input.
// Strobes are 0-cycle from registers; config takes effect at the owning channel's next period boundary.
// o_cfg_ready drops only for the addressed channel while its previous write is still pending.
module strobe_div_bank
    import strobe_pkg::*;
#(
    parameter  int NUM_CH      = 4,
    parameter  int CNT_W       = 16,
    parameter  int DEFAULT_DIV = 10,
    localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_cfg_valid,
    output logic              o_cfg_ready,
    input  logic [CH_W-1:0]   i_cfg_ch,
    input  logic [CNT_W-1:0]  i_cfg_div,
    input  logic [1:0]        i_cfg_mode,
    input  logic [NUM_CH-1:0] i_start,
    input  logic              i_sync,
    output logic [NUM_CH-1:0] o_strobe,
    output logic [NUM_CH-1:0] o_busy
);

    if (NUM_CH < 1) begin : g_bad_num_ch
        $error("strobe_div_bank: NUM_CH must be >= 1");
    end
    if ((CNT_W < 2) || (CNT_W > 64)) begin : g_bad_cnt_w
        $error("strobe_div_bank: CNT_W must be in 2..64");
    end
    if ((DEFAULT_DIV < 2) || ((CNT_W < 31) && (DEFAULT_DIV > (1 << CNT_W) - 1))) begin : g_bad_div
        $error("strobe_div_bank: DEFAULT_DIV must be in 2..2**CNT_W-1");
    end

    logic [NUM_CH-1:0] pend;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        strobe_div_chan #(
            .CNT_W       (CNT_W),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_chan (
            .i_clk      (i_clk),
            .i_reset_n  (i_reset_n),
            .i_cfg_wr   (i_cfg_valid && (i_cfg_ch == CH_W'(g))),
            .i_cfg_div  (i_cfg_div),
            .i_cfg_mode (i_cfg_mode),
            .i_start    (i_start[g]),
            .i_sync     (i_sync),
            .o_strobe   (o_strobe[g]),
            .o_busy     (o_busy[g]),
            .o_pending  (pend[g])
        );
    end

    // Unpopulated channel indices stay ready so a stray write cannot wedge the port.
    always_comb begin
        o_cfg_ready = 1'b1;
        for (int i = 0; i < NUM_CH; i++) begin
            if (i_cfg_ch == CH_W'(i)) begin
                o_cfg_ready = !pend[i];
            end
        end
    end

endmodule

// File: tb/tb_strobe_div_bank.sv
// Directed bench for strobe_div_bank: expected strobe/busy come from a per-channel phase tracker
// advanced once per edge, with config apply points and sync/reset effects written in by each step.
module tb_strobe_div_bank;
    import strobe_pkg::*;

    localparam int NCH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        cfg_vld = 1'b0;
    logic        cfg_rdy;
    logic [1:0]  cfg_ch = 2'd0;
    logic [15:0] cfg_div = 16'd0;
    logic [1:0]  cfg_mode = 2'd0;
    logic [3:0]  start = 4'd0;
    logic        sync = 1'b0;
    logic [3:0]  strobe;
    logic [3:0]  busy;

    int ncmp = 0;
    int nerr = 0;

    int ph[NCH];
    int per[NCH];
    bit os[NCH];
    bit bz[NCH];

    always #5 clk = ~clk;

    strobe_div_bank #(
        .NUM_CH      (4),
        .CNT_W       (16),
        .DEFAULT_DIV (10)
    ) dut (
        .i_clk       (clk),
        .i_reset_n   (rst_n),
        .i_cfg_valid (cfg_vld),
        .o_cfg_ready (cfg_rdy),
        .i_cfg_ch    (cfg_ch),
        .i_cfg_div   (cfg_div),
        .i_cfg_mode  (cfg_mode),
        .i_start     (start),
        .i_sync      (sync),
        .o_strobe    (strobe),
        .o_busy      (busy)
    );

    task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            ph[c]  = 0;
            per[c] = 10;
            os[c]  = 1'b0;
            bz[c]  = 1'b0;
        end
    endtask

    task automatic chk(input string tag);
        logic [3:0] es;
        logic [3:0] eb;
        for (int c = 0; c < NCH; c++) begin
            es[c] = ((!os[c]) || bz[c]) && (ph[c] == per[c] - 1);
            eb[c] = os[c] && bz[c];
        end
        cmp({tag, "_strobe"}, 32'(strobe), 32'(es));
        cmp({tag, "_busy"}, 32'(busy), 32'(eb));
    endtask

    // Advance the tracker across one rising edge using the inputs driven before it.
    task automatic adv();
        logic [3:0] st;
        logic       sy;
        st = start;
        sy = sync;
        @(posedge clk);
        #1;
        for (int c = 0; c < NCH; c++) begin
            if (sy) begin
                ph[c] = 0;
            end else if (!os[c]) begin
                ph[c] = (ph[c] + 1) % per[c];
            end else if (bz[c]) begin
                if (ph[c] == per[c] - 1) begin
                    bz[c] = st[c];
                    ph[c] = 0;
                end else begin
                    ph[c] = ph[c] + 1;
                end
            end else if (st[c]) begin
                bz[c] = 1'b1;
                ph[c] = 0;
            end
        end
    endtask

    task automatic run(input int n, input string tag);
        repeat (n) begin
            adv();
            chk(tag);
        end
    endtask

    // Pending config on a continuous channel lands on the edge after its next strobe.
    task automatic wait_apply(input int c, input int np, input bit o);
        while (ph[c] != per[c] - 1) begin
            adv();
            chk("pre_apply");
        end
        adv();
        ph[c]  = 0;
        per[c] = np;
        os[c]  = o;
        bz[c]  = 1'b0;
        chk("apply");
    endtask

    task automatic cfg_write(input logic [1:0] ch, input logic [15:0] dv, input logic [1:0] md);
        cfg_ch   = ch;
        cfg_div  = dv;
        cfg_mode = md;
        cfg_vld  = 1'b1;
        #1;
        cmp("cfg_rdy_before_write", 32'(cfg_rdy), 32'd1);
        adv();
        chk("cfg_accept");
        cfg_vld = 1'b0;
    endtask

    initial begin
        model_reset();
        #1 rst_n = 1'b0;
        #1;
        cmp("reset_strobe", 32'(strobe), 32'd0);
        cmp("reset_busy", 32'(busy), 32'd0);
        cmp("reset_cfg_rdy", 32'(cfg_rdy), 32'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Default divide-by-10: strobes visible on edges 10, 20, 30.
        run(30, "default");
        cmp("default_cfg_rdy", 32'(cfg_rdy), 32'd1);

        // ch1 -> div 3 while its counter is at 4; ch2 written while ch1 is blocked.
        run(4, "pre_wr");
        cfg_ch   = 2'd1;
        cfg_div  = 16'd3;
        cfg_mode = MODE_CONT;
        cfg_vld  = 1'b1;
        #1;
        cmp("ch1_rdy_free", 32'(cfg_rdy), 32'd1);
        adv();
        chk("ch1_accept");
        cmp("ch1_rdy_pending", 32'(cfg_rdy), 32'd0);
        cfg_ch  = 2'd2;
        cfg_div = 16'd10;
        #1;
        cmp("ch2_rdy_while_ch1_pending", 32'(cfg_rdy), 32'd1);
        adv();
        chk("ch2_accept");
        cfg_vld = 1'b0;
        cfg_ch  = 2'd1;
        #1;
        cmp("ch1_rdy_hold", 32'(cfg_rdy), 32'd0);
        wait_apply(1, 3, 1'b0);
        cmp("ch1_rdy_after_apply", 32'(cfg_rdy), 32'd1);
        run(20, "div3");

        // Divisors 0 and 1 both clamp to 2.
        cfg_write(2'd1, 16'd0, MODE_CONT);
        wait_apply(1, 2, 1'b0);
        run(6, "div0");
        cfg_write(2'd1, 16'd1, MODE_CONT);
        run(8, "div1");

        // Largest divisor: one full period plus the wrap.
        cfg_write(2'd3, 16'hFFFF, MODE_CONT);
        wait_apply(3, 65535, 1'b0);
        run(65536, "div_max");

        // Restore ch3 to 10 and let sync apply it.
        cfg_write(2'd3, 16'd10, MODE_CONT);
        cmp("ch3_rdy_pending", 32'(cfg_rdy), 32'd0);
        run(3, "pre_sync");
        sync = 1'b1;
        adv();
        per[3] = 10;
        chk("sync");
        sync = 1'b0;
        cmp("ch3_rdy_after_sync", 32'(cfg_rdy), 32'd1);
        run(12, "post_sync");

        // Sync on a strobe cycle keeps that strobe.
        while (ph[0] != 9) begin
            adv();
            chk("to_strobe");
        end
        sync = 1'b1;
        #1;
        chk("sync_on_strobe");
        adv();
        chk("after_sync_strobe");
        sync = 1'b0;
        run(3, "post_sync2");

        // ch2 one-shot, div 5.
        cfg_write(2'd2, 16'd5, MODE_ONESHOT);
        wait_apply(2, 5, 1'b1);
        run(2, "os_idle");
        start[2] = 1'b1;
        adv();
        start = 4'd0;
        chk("os_start");
        run(3, "os_run");
        start[2] = 1'b1;
        adv();
        start = 4'd0;
        chk("os_start_ignored");
        start[2] = 1'b1;
        adv();
        start = 4'd0;
        chk("os_retrigger");
        run(7, "os_tail");

        // Async reset mid-period with a pending config and a live one-shot.
        while (!(ph[1] == 0 && ph[3] < 8)) begin
            adv();
            chk("pre_reset");
        end
        start[2] = 1'b1;
        cfg_write(2'd3, 16'd7, MODE_CONT);
        start = 4'd0;
        cmp("ch3_rdy_before_reset", 32'(cfg_rdy), 32'd0);
        cmp("busy_before_reset", 32'(busy), 32'h4);
        #2 rst_n = 1'b0;
        #1;
        cmp("async_reset_strobe", 32'(strobe), 32'd0);
        cmp("async_reset_busy", 32'(busy), 32'd0);
        cmp("async_reset_cfg_rdy", 32'(cfg_rdy), 32'd1);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        run(25, "post_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
